// File: rtl/dac_pulse_packer.sv
// dac_pulse_packer: packs a FIFO'd scalar amplitude stream into 16-lane DAC frames at a programmed slot period.
// Config arrives over the shared GPIO bus; lane window and period changes apply only at slot boundaries.
module dac_pulse_packer #(
   parameter logic [15:0] ADDR_PERIOD = 16'd8,
   parameter logic [15:0] ADDR_OFFSET = 16'd9,
   parameter logic [15:0] ADDR_WIDTH  = 16'd10,
   parameter logic [15:0] ADDR_CTRL   = 16'd11,
   parameter int          FIFO_DEPTH  = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  gpio_in,
   input  logic [15:0]  val_in,
   input  logic         val_in_valid,
   output logic         val_in_ready,
   output logic [255:0] fsm_val_out,
   output logic         fsm_out_valid,
   output logic         pulse_sync,
   output logic         underflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   logic [1:0]  w_sync;
   logic        w_prev, we;
   logic [15:0] addr;
   logic [7:0]  data;
   logic [7:0]  period, cnt;
   logic [3:0]  offset, sh_offset;
   logic [4:0]  width, sh_width;
   logic        enable, flush_q, clr_q, slot;
   logic [15:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] count, count_nx;
   logic        push, pop, empty;
   logic [15:0] val_q;
   logic [5:0]  lo, hi;
   logic        unused_bits;

   assign addr        = gpio_in[15:0];
   assign data        = gpio_in[23:16];
   assign unused_bits = ^gpio_in[31:25];
   assign we          = w_sync[1] & ~w_prev;
   assign slot        = enable && cnt == 8'd0;
   assign empty       = count == '0;
   assign push        = val_in_valid && val_in_ready && !flush_q;
   assign pop         = slot && !empty && !flush_q;
   assign count_nx    = flush_q ? '0 : count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_sync  <= '0;
         w_prev  <= 1'b0;
         period  <= 8'd4;
         offset  <= 4'd0;
         width   <= 5'd8;
         enable  <= 1'b0;
         flush_q <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         w_sync  <= {w_sync[0], gpio_in[24]};
         w_prev  <= w_sync[1];
         flush_q <= we && addr == ADDR_CTRL && data[1];
         clr_q   <= we && addr == ADDR_CTRL && data[2];
         if (we && addr == ADDR_PERIOD) period <= data;
         if (we && addr == ADDR_OFFSET) offset <= data[3:0];
         if (we && addr == ADDR_WIDTH) width <= data[4:0];
         if (we && addr == ADDR_CTRL) enable <= data[0];
      end
   end

   // A flush cycle discards the concurrent push and makes any slot in it see an empty FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp           <= '0;
         rp           <= '0;
         count        <= '0;
         val_in_ready <= 1'b0;
      end else begin
         count        <= count_nx;
         val_in_ready <= count_nx != FULL_CNT;
         wp           <= flush_q ? '0 : push ? wp + AW'(1) : wp;
         rp           <= flush_q ? '0 : pop ? rp + AW'(1) : rp;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= val_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt           <= 8'd0;
         sh_offset     <= 4'd0;
         sh_width      <= 5'd8;
         val_q         <= 16'd0;
         fsm_out_valid <= 1'b0;
         pulse_sync    <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         cnt           <= !enable ? 8'd0 : slot ? (period == 8'd0 ? 8'd0 : period - 8'd1) : cnt - 8'd1;
         sh_offset     <= slot ? offset : sh_offset;
         sh_width      <= slot ? (width == 5'd0 ? 5'd1 : width) : sh_width;
         val_q         <= pop ? mem[rp] : 16'd0;
         fsm_out_valid <= enable;
         pulse_sync    <= slot;
         underflow     <= (slot && !pop) || (underflow && !clr_q);
      end
   end

   // Lane window comes from the shadows latched in the same slot as val_q, so each frame is self-consistent.
   assign lo = {2'b00, sh_offset};
   assign hi = lo + {1'b0, sh_width};
   for (genvar k = 0; k < 16; k++) begin : g_lane
      assign fsm_val_out[16*k +: 16] = (6'(k) >= lo && 6'(k) < hi) ? val_q : 16'd0;
   end
endmodule

// File: tb/tb_dac_pulse_packer.sv
// tb_dac_pulse_packer: directed stimulus with a frame scoreboard drained by an independent monitor.
module tb_dac_pulse_packer;
   localparam logic [15:0] A_PER = 16'd8, A_OFF = 16'd9, A_WID = 16'd10, A_CTL = 16'd11;
   typedef struct {
      logic [255:0] val;
      logic         sync;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  gpio_in;
   logic [15:0]  val_in;
   logic         val_in_valid;
   logic         val_in_ready;
   logic [255:0] fsm_val_out;
   logic         fsm_out_valid;
   logic         pulse_sync;
   logic         underflow;
   exp_t         exp_q[$];
   exp_t         mon_e;
   logic [15:0]  vq[$];
   int           n_chk = 0;
   int           n_fail = 0;

   dac_pulse_packer dut (
      .clk(clk), .rst(rst), .gpio_in(gpio_in), .val_in(val_in), .val_in_valid(val_in_valid),
      .val_in_ready(val_in_ready), .fsm_val_out(fsm_val_out), .fsm_out_valid(fsm_out_valid),
      .pulse_sync(pulse_sync), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
      end
   endtask

   function automatic logic [255:0] frame(input logic [15:0] v, input int off, input int w);
      int we = (w == 0) ? 1 : w;
      logic [255:0] f = '0;
      for (int k = 0; k < 16; k++)
         if (k >= off && k < off + we) f[16*k +: 16] = v;
      return f;
   endfunction

   always @(negedge clk) begin
      if (rst && fsm_out_valid && exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("frame", fsm_val_out, mon_e.val);
         chk("pulse_sync", 256'(pulse_sync), 256'(mon_e.sync));
      end
   end

   task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold = 4);
      @(negedge clk);
      gpio_in = {7'b0, 1'b1, d, a};
      repeat (hold) @(negedge clk);
      gpio_in[24] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic push(input logic [15:0] v);
      int t = 0;
      @(negedge clk);
      val_in = v;
      val_in_valid = 1'b1;
      while (!val_in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("push_ready", 256'(val_in_ready), 256'(1));
      @(posedge clk);
      #1 val_in_valid = 1'b0;
   endtask

   task automatic enqueue(input int per, input int off, input int wid, input int nf);
      int pe = (per == 0) ? 1 : per;
      exp_t e;
      for (int j = 0; j < nf; j++) begin
         e.sync = (j % pe == 0);
         e.val = '0;
         if (e.sync && j / pe < vq.size()) e.val = frame(vq[j / pe], off, wid);
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 256'(exp_q.size()), 256'(0));
   endtask

   task automatic start(input int per, input int off, input int wid, input int nf);
      foreach (vq[i]) push(vq[i]);
      enqueue(per, off, wid, nf);
      wr(A_CTL, 8'h01);
      drain();
      wr(A_CTL, 8'h02);
      @(negedge clk);
      chk("idle_out", 256'({fsm_out_valid, pulse_sync, |fsm_val_out}), 256'(0));
   endtask

   task automatic window(input int per, input int off, input int wid, input int nf);
      wr(A_PER, 8'(per));
      wr(A_OFF, 8'(off));
      wr(A_WID, 8'(wid));
      start(per, off, wid, nf);
   endtask

   initial begin
      int   acc;
      int   t;
      logic pr;
      rst = 1'b0;
      gpio_in = '0;
      val_in = '0;
      val_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_out", 256'({val_in_ready, fsm_out_valid, pulse_sync, underflow, |fsm_val_out}), 256'(0));
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 256'(val_in_ready), 256'(1));
      wr(16'd12, 8'h01);
      repeat (3) @(negedge clk);
      chk("unknown_addr", 256'(fsm_out_valid), 256'(0));

      vq = '{16'h1234, 16'h8001};
      window(4, 7, 8, 8);
      chk("underflow_set", 256'(underflow), 256'(1));
      wr(A_CTL, 8'h04);
      chk("underflow_clr", 256'(underflow), 256'(0));
      vq = {};
      start(4, 7, 8, 9);
      chk("underflow_empty", 256'(underflow), 256'(1));

      acc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         val_in = 16'h0100 + 16'(acc);
         val_in_valid = 1'b1;
         if (val_in_ready) acc++;
      end
      @(negedge clk);
      val_in_valid = 1'b0;
      chk("fill_count", 256'(acc), 256'(16));
      chk("full_ready", 256'(val_in_ready), 256'(0));
      vq = '{16'h0100, 16'h0101, 16'h0102};
      enqueue(4, 7, 8, 9);
      @(negedge clk);
      gpio_in = {7'b0, 1'b1, 8'h01, A_CTL};
      pr = val_in_ready;
      t = 0;
      while (!fsm_out_valid && t < 20) begin
         pr = val_in_ready;
         @(negedge clk);
         t++;
      end
      chk("ready_before_pop", 256'(pr), 256'(0));
      chk("ready_after_pop", 256'(val_in_ready), 256'(1));
      gpio_in[24] = 1'b0;
      drain();
      wr(A_CTL, 8'h02);
      chk("ready_after_flush", 256'(val_in_ready), 256'(1));

      vq = '{16'hAAAA, 16'h5555};
      window(2, 12, 8, 4);
      vq = '{16'h7FFF, 16'h0001};
      window(3, 3, 0, 6);
      vq = '{16'h0001, 16'h0002, 16'h0003};
      window(0, 0, 16, 4);
      chk("underflow_per0", 256'(underflow), 256'(1));

      wr(A_PER, 8'd6);
      wr(A_OFF, 8'd0);
      wr(A_WID, 8'd1);
      vq = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
      foreach (vq[i]) push(vq[i]);
      for (int j = 0; j <= 10; j++) begin
         exp_t e;
         e.sync = (j == 0 || j == 6 || j == 8 || j == 10);
         e.val = (j == 0) ? frame(vq[0], 0, 1) : (j == 6) ? frame(vq[1], 0, 1) :
                 (j == 8) ? frame(vq[2], 0, 1) : '0;
         exp_q.push_back(e);
      end
      @(negedge clk);
      gpio_in = {7'b0, 1'b1, 8'h01, A_CTL};
      repeat (2) @(negedge clk);
      gpio_in[24] = 1'b0;
      wr(A_PER, 8'd2);
      drain();
      @(negedge clk);
      gpio_in = {7'b0, 1'b1, 8'h05, A_CTL};
      repeat (10) @(negedge clk);
      t = 0;
      repeat (40) begin
         @(negedge clk);
         if (!underflow) t++;
      end
      gpio_in[24] = 1'b0;
      repeat (3) @(negedge clk);
      chk("one_write_per_edge", 256'(t), 256'(0));
      wr(A_CTL, 8'h02);

      wr(A_PER, 8'd4);
      for (int i = 0; i < 8; i++) push(16'h0F00 + 16'(i));
      vq = {};
      enqueue(4, 0, 1, 9);
      @(negedge clk);
      gpio_in = {7'b0, 1'b1, 8'h03, A_CTL};
      val_in = 16'hDEAD;
      val_in_valid = 1'b1;
      repeat (4) @(negedge clk);
      val_in_valid = 1'b0;
      gpio_in[24] = 1'b0;
      drain();
      chk("underflow_flush", 256'(underflow), 256'(1));
      wr(A_CTL, 8'h02);

      wr(A_PER, 8'd8);
      push(16'hBEEF);
      push(16'h2222);
      push(16'h3333);
      wr(A_CTL, 8'h01);
      t = 0;
      while (!(|fsm_val_out) && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("frame_before_reset", 256'(|fsm_val_out), 256'(1));
      rst = 1'b0;
      #1;
      chk("reset_mid_frame", 256'({val_in_ready, fsm_out_valid, pulse_sync, underflow, |fsm_val_out}), 256'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst2", 256'(val_in_ready), 256'(1));
      vq = '{16'h0042};
      start(4, 0, 8, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
